// File: rtl/mem_arb_pkg.sv
// Purpose: shared encodings and default widths for the memory-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_e (IDLE/GRANT0/GRANT1/GAP, 2-bit), default line/address widths.
package mem_arb_pkg;

  localparam int DATA_W_DEF = 256;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    GAP    = 2'd3
  } state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Purpose: two-way round-robin pick, one-hot result.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req_i[1:0] requests, last_i last master served, pick_o[1:0] one-hot winner (00 if no request).
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] pick_o
);

  always_comb begin
    pick_o = req_i;
    // On a tie the master that was not served last wins.
    if (req_i == 2'b11) begin
      pick_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: shares one line-wide memory port between the data cache (m0) and instruction cache (m1).
// Latency: request seen at IDLE edge -> mem_enable_o next cycle; ack passes through same cycle; 2 dead cycles after each ack.
// Backpressure: losing master simply stays unacked until its turn; grant held until mem ack or requester abort.
// Ports: clk_i, rst_i (async active-low); m{0,1}_{enable,write,addr,data}_i / m{0,1}_{data,ack}_o master side;
//        mem_{enable,write,addr,data}_o / mem_{data,ack}_i memory side; grant_o one-hot owner (00 when idle).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // master 0 (data cache)
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  // master 1 (instruction cache)
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  // memory side
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  // current owner
  output logic [1:0]        grant_o
);

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] pick;

  rr_pick2 u_pick (
    .req_i  ({m1_enable_i, m0_enable_i}),
    .last_i (last_q),
    .pick_o (pick)
  );

  // last resets to 1 so the data cache wins the first tie.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    m0_ack_o     = 1'b0;
    m0_data_o    = '0;
    m1_ack_o     = 1'b0;
    m1_data_o    = '0;
    grant_o      = 2'b00;

    unique case (state_q)
      IDLE: begin
        // Stray memory acks here are dropped: nothing is forwarded.
        if (pick[0]) begin
          state_d = GRANT0;
        end else if (pick[1]) begin
          state_d = GRANT1;
        end
      end

      GRANT0: begin
        grant_o      = 2'b01;
        mem_enable_o = m0_enable_i;
        mem_write_o  = m0_write_i;
        mem_addr_o   = m0_addr_i;
        mem_data_o   = m0_data_i;
        m0_ack_o     = mem_ack_i;
        m0_data_o    = mem_data_i;
        // Completion takes precedence over a same-cycle enable drop.
        if (mem_ack_i) begin
          state_d = GAP;
          last_d  = 1'b0;
        end else if (!m0_enable_i) begin
          state_d = GAP;
        end
      end

      GRANT1: begin
        grant_o      = 2'b10;
        mem_enable_o = m1_enable_i;
        mem_write_o  = m1_write_i;
        mem_addr_o   = m1_addr_i;
        mem_data_o   = m1_data_i;
        m1_ack_o     = mem_ack_i;
        m1_data_o    = mem_data_i;
        if (mem_ack_i) begin
          state_d = GAP;
          last_d  = 1'b1;
        end else if (!m1_enable_i) begin
          state_d = GAP;
        end
      end

      GAP: begin
        // Together with IDLE this keeps mem_enable_o low for two cycles,
        // letting the memory's cycle counter restart between transactions.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
